// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 digit transmitter: scancode table, frame constants, FSM states.
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam int         FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_NEXT = 2'd3
    } ps2_state_e;

    function automatic logic [7:0] digit_to_scan(input logic [3:0] digit);
        logic [7:0] scan;
        case (digit)
            4'd0:    scan = 8'h45;
            4'd1:    scan = 8'h16;
            4'd2:    scan = 8'h1E;
            4'd3:    scan = 8'h26;
            4'd4:    scan = 8'h25;
            4'd5:    scan = 8'h2E;
            4'd6:    scan = 8'h36;
            4'd7:    scan = 8'h3D;
            4'd8:    scan = 8'h3E;
            4'd9:    scan = 8'h46;
            default: scan = 8'h00;
        endcase
        return scan;
    endfunction

    // Odd parity bit: data plus parity carries an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Single-byte PS/2 device-to-host serializer; owns the pins and the inter-frame gap.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int              GW         = $clog2(GAP + 1);
    localparam logic [PW-1:0]   PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [GW-1:0]   GAP_LAST   = GW'((GAP >= 2) ? (GAP - 2) : 0);
    localparam logic [3:0]      STOP_BIT   = 4'(FRAME_BITS - 1);

    ps2_state_e      state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [3:0]      bit_q, bit_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [9:0]      shift_q, shift_d;
    logic            clk_q, clk_d;
    logic            data_q, data_d;
    logic [10:0]     frame_s;

    assign frame_s    = {1'b1, odd_parity(byte_data), byte_data, 1'b0};
    // NEXT is the last gap cycle: the following byte is taken here so frames abut the gap.
    assign byte_ready = (state_q == ST_IDLE) || (state_q == ST_NEXT);
    assign ps2_clk    = clk_q;
    assign ps2_data   = data_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        clk_d   = clk_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE, ST_NEXT: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (byte_valid) begin
                    state_d = ST_SEND;
                    phase_d = {PW{1'b0}};
                    bit_d   = 4'd0;
                    data_d  = frame_s[0];
                    shift_d = frame_s[10:1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = {PW{1'b0}};
                    if (clk_q) begin
                        clk_d = 1'b0;
                    end else if (bit_q == STOP_BIT) begin
                        clk_d   = 1'b1;
                        data_d  = 1'b1;
                        gap_d   = {GW{1'b0}};
                        state_d = (GAP == 1) ? ST_NEXT : ST_GAP;
                    end else begin
                        clk_d   = 1'b1;
                        data_d  = shift_q[0];
                        shift_d = {1'b1, shift_q[9:1]};
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= {PW{1'b0}};
            bit_q   <= 4'd0;
            gap_q   <= {GW{1'b0}};
            shift_q <= 10'h3FF;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/ps2_digit_tx.sv
// Keyboard-side PS/2 transmitter: validates a digit and sequences make / F0 / make bytes.
module ps2_digit_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    input  logic       in_release,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       err
);

    logic       in_ready_q, in_ready_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic       rel_q, rel_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] scan_q, scan_d;
    logic       accept_s, legal_s, more_s;
    logic       byte_valid_s, byte_ready_s;
    logic [7:0] byte_data_s;

    assign legal_s  = (in_digit <= 4'd9);
    assign accept_s = in_ready_q && in_valid;
    // idx is the byte on the wire; a release sequence has bytes 0..2.
    assign more_s   = rel_q && (idx_q != 2'd2);

    always_comb begin
        byte_valid_s = 1'b0;
        byte_data_s  = digit_to_scan(in_digit);
        if (busy_q) begin
            byte_valid_s = more_s;
            byte_data_s  = (idx_q == 2'd0) ? BREAK_CODE : scan_q;
        end else begin
            byte_valid_s = accept_s && legal_s;
        end
    end

    always_comb begin
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        rel_d      = rel_q;
        idx_d      = idx_q;
        scan_d     = scan_q;
        if (accept_s) begin
            if (legal_s) begin
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
                rel_d      = in_release;
                idx_d      = 2'd0;
                scan_d     = digit_to_scan(in_digit);
            end else begin
                err_d = 1'b1;
            end
        end else if (busy_q && byte_ready_s) begin
            if (more_s) begin
                idx_d = idx_q + 2'd1;
            end else begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rel_q      <= 1'b0;
            idx_q      <= 2'd0;
            scan_q     <= 8'h00;
        end else begin
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rel_q      <= rel_d;
            idx_q      <= idx_d;
            scan_q     <= scan_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign err      = err_q;

    ps2_frame_tx #(
        .CLK_DIV (CLK_DIV),
        .GAP     (GAP)
    ) u_frame_tx (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .byte_ready (byte_ready_s),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data)
    );

endmodule

// File: tb/tb_ps2_digit_tx.sv
// Directed bench for ps2_digit_tx: decodes frames off the pins and checks timing and content.
module tb_ps2_digit_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;
    localparam int SEQ_LEN = 22 * CLK_DIV + GAP;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_digit = 4'd0;
    logic       in_release = 1'b0;
    logic       in_ready, ps2_clk, ps2_data, busy, err;

    int n_vec = 0;
    int n_mis = 0;

    logic [7:0] scan_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    typedef struct {
        logic [3:0] digit;
        logic       rel;
        int         nb;
        logic [7:0] make;
    } vec_t;

    ps2_digit_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_digit   (in_digit),
        .in_release (in_release),
        .in_ready   (in_ready),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Host-side receiver: sample data on each ps2_clk falling edge, 11 bits per frame.
    logic [10:0] mon_sh = 11'd0;
    int          mon_n = 0;
    logic [10:0] raw_q [$];
    always @(negedge ps2_clk or posedge reset) begin
        if (reset) begin
            mon_n = 0;
        end else begin
            mon_sh = {ps2_data, mon_sh[10:1]};
            mon_n++;
            if (mon_n == 11) begin
                raw_q.push_back(mon_sh);
                mon_n = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scancode decoder model: returns {valid, digit}.
    function automatic logic [4:0] decode(input logic [7:0] b);
        case (b)
            8'h45: return {1'b1, 4'd0};
            8'h16: return {1'b1, 4'd1};
            8'h1E: return {1'b1, 4'd2};
            8'h26: return {1'b1, 4'd3};
            8'h25: return {1'b1, 4'd4};
            8'h2E: return {1'b1, 4'd5};
            8'h36: return {1'b1, 4'd6};
            8'h3D: return {1'b1, 4'd7};
            8'h3E: return {1'b1, 4'd8};
            8'h46: return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    // Call at a negedge with in_ready=1; request is accepted on the next posedge (cycle 0).
    task automatic send_req(input logic [3:0] d, input logic r, output int len, output int errs,
                            output int lows, output int rdy_low, output bit busy_bad);
        int n;
        len = 0; errs = 0; lows = 0; rdy_low = 0; busy_bad = 1'b0;
        in_valid = 1'b1; in_digit = d; in_release = r;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (n < 1200 && !(len != 0 && n > len + 3)) begin
            if (err) errs++;
            if (!ps2_clk) lows++;
            if (!in_ready) rdy_low++;
            if (len == 0) begin
                if (in_ready && !busy) len = n;
                else if (!busy || in_ready) busy_bad = 1'b1;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        ok = 1'b0;
        for (n = 0; n < 1200 && !ok; n++) begin
            if (in_ready && !busy) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic chk_frame(input string name, input logic [10:0] raw, input logic [7:0] exp);
        chk({name, "_byte"}, {24'd0, raw[8:1]}, {24'd0, exp});
        chk({name, "_fmt"}, {29'd0, raw[10], raw[0], ^raw[9:1]}, 32'd5);
    endtask

    initial begin
        vec_t vt [6];
        int len, errs, lows, rdy_low, base, n;
        bit busy_bad, ok;
        logic [7:0] exp_b;

        vt[0] = '{4'd0,  1'b0, 1, 8'h45};
        vt[1] = '{4'd2,  1'b1, 3, 8'h1E};
        vt[2] = '{4'd12, 1'b0, 0, 8'h00};
        vt[3] = '{4'd9,  1'b1, 3, 8'h46};
        vt[4] = '{4'd5,  1'b0, 1, 8'h2E};
        vt[5] = '{4'd15, 1'b1, 0, 8'h00};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_clk",   {31'd0, ps2_clk},  32'd1);
        chk("rst_data",  {31'd0, ps2_data}, 32'd1);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_err",   {31'd0, err},      32'd0);

        // Digit 0: start bit and first falling edge timing, then the raw 11-bit frame.
        base = raw_q.size();
        in_valid = 1'b1; in_digit = 4'd0; in_release = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("start_bit", {30'd0, ps2_clk, ps2_data}, 32'd2);
        n = 1;
        while (n < 20 && ps2_clk) begin
            @(negedge clk);
            n++;
        end
        chk("first_fall", n, 32'd5);
        wait_idle(ok);
        chk("idle0", {31'd0, ok}, 32'd1);
        chk("raw45_count", raw_q.size() - base, 32'd1);
        if (raw_q.size() > base) chk("raw45", {21'd0, raw_q[base]}, 32'h48A);

        // Table-driven requests.
        for (int i = 0; i < 6; i++) begin
            base = raw_q.size();
            send_req(vt[i].digit, vt[i].rel, len, errs, lows, rdy_low, busy_bad);
            chk("len", len, (vt[i].nb == 0) ? 32'd1 : 32'(SEQ_LEN * vt[i].nb + 1));
            chk("err_pulses", errs, (vt[i].nb == 0) ? 32'd1 : 32'd0);
            chk("clk_low_cycles", lows, 32'(11 * CLK_DIV * vt[i].nb));
            chk("ready_low_cycles", rdy_low, 32'(SEQ_LEN * vt[i].nb));
            chk("busy_span", {31'd0, busy_bad}, 32'd0);
            chk("nbytes", raw_q.size() - base, 32'(vt[i].nb));
            for (int j = 0; j < vt[i].nb && base + j < raw_q.size(); j++) begin
                exp_b = (j == 1) ? 8'hF0 : vt[i].make;
                chk_frame("seq", raw_q[base + j], exp_b);
            end
        end

        // Held in_valid with in_digit changing mid-frame.
        base = raw_q.size();
        in_valid = 1'b1; in_digit = 4'd7; in_release = 1'b0;
        @(negedge clk);
        n = 1; len = 0;
        while (n < 400 && len == 0) begin
            if (n == 40) in_digit = 4'd9;
            if (n == 80) in_digit = 4'd7;
            if (in_ready) len = n;
            else begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_len", len, 32'(SEQ_LEN + 1));
        chk("hold_reaccept", {30'd0, in_ready, busy}, 32'd1);
        wait_idle(ok);
        chk("hold_idle", {31'd0, ok}, 32'd1);
        chk("hold_nbytes", raw_q.size() - base, 32'd2);
        for (int j = 0; j < 2 && base + j < raw_q.size(); j++) chk_frame("hold", raw_q[base + j], 8'h3D);

        // Reset during bit 5 of a frame.
        base = raw_q.size();
        in_valid = 1'b1; in_digit = 4'd4; in_release = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (43) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_lines", {28'd0, ps2_clk, ps2_data, in_ready, busy}, 32'hE);
        chk("abort_nbytes", raw_q.size() - base, 32'd0);
        base = raw_q.size();
        send_req(4'd3, 1'b0, len, errs, lows, rdy_low, busy_bad);
        chk("post_abort_len", len, 32'(SEQ_LEN + 1));
        chk("post_abort_nbytes", raw_q.size() - base, 32'd1);
        if (raw_q.size() > base) chk_frame("post_abort", raw_q[base], 8'h26);

        // All digits through the decoder model.
        for (int d = 0; d < 10; d++) begin
            base = raw_q.size();
            send_req(4'(d), 1'b0, len, errs, lows, rdy_low, busy_bad);
            chk("loop_nbytes", raw_q.size() - base, 32'd1);
            if (raw_q.size() > base) begin
                chk("loop_scan", {24'd0, raw_q[base][8:1]}, {24'd0, scan_tab[d]});
                chk("loop_decode", {27'd0, decode(raw_q[base][8:1])}, {27'd0, 1'b1, 4'(d)});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
